// File: rtl/ysyx_24110015_axi_pkg.sv
// Shared types and address map for the memory-side AXI-lite crossbar.
// Select, response and FSM state encodings live here.
package ysyx_24110015_axi_pkg;

  localparam logic [31:0] UART_BASE = 32'ha000_03f8;
  localparam logic [31:0] UART_MASK = 32'hffff_fff8;
  localparam logic [31:0] SRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] SRAM_MASK = 32'hf800_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SEL_SRAM,
    SEL_UART,
    SEL_ERR
  } sel_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_WAIT,
    R_RESP
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FWD,
    W_WAIT,
    W_RESP
  } wstate_e;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle: 32-bit address/data, 4-bit strobe, 2-bit response.
// master drives requests, slave drives readies and responses.
interface axi_lite_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_24110015_Reg.sv
// Generic enable register with asynchronous active-low reset.
// Used for every latched field of the crossbar.
module ysyx_24110015_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24110015_addr_decode.sv
// Address to slave select. UART and SRAM windows are disjoint;
// anything outside both maps to the internal error responder.
module ysyx_24110015_addr_decode
  import ysyx_24110015_axi_pkg::*;
(
  input  logic [31:0] addr,
  output sel_e        sel
);

  logic uart_hit;
  logic sram_hit;

  assign uart_hit = (addr & UART_MASK) == UART_BASE;
  assign sram_hit = (addr & SRAM_MASK) == SRAM_BASE;

  always_comb begin
    sel = SEL_ERR;
    unique case (1'b1)
      uart_hit: sel = SEL_UART;
      sram_hit: sel = SEL_SRAM;
      default:  sel = SEL_ERR;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_axi_xbar.sv
// AXI-lite 1-to-2 crossbar: core master to SRAM and UART slaves.
// Independent read/write FSMs, one transaction each, fully registered.
module ysyx_24110015_axi_xbar
  import ysyx_24110015_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  up,
  axi_lite_if.master sram,
  axi_lite_if.master uart
);

  // readies stay low for the first cycle after reset release
  logic live_q, live_d;

  rstate_e     r_q, r_d;
  sel_e        ar_sel, rsel_q;
  logic [1:0]  rsel_raw;
  logic [31:0] araddr_q, rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs, rcap;
  logic        s_arready, s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  wstate_e     w_q, w_d;
  sel_e        aw_sel, wsel_q;
  logic [1:0]  wsel_raw;
  logic [31:0] awaddr_q, wdata_q, aw_cur;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        aw_hs, w_hs, both, sel_wen, bcap;
  logic        s_awready, s_wready, s_bvalid;
  logic [1:0]  s_bresp;
  logic        s_awvalid, s_wvalid, s_aw_hs, s_w_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q    <= 1'b0;
      r_q       <= R_IDLE;
      w_q       <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      live_q    <= live_d;
      r_q       <= r_d;
      w_q       <= w_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  ysyx_24110015_addr_decode u_rdec (
    .addr (up.araddr),
    .sel  (ar_sel)
  );

  assign ar_hs  = up.arvalid & up.arready;
  assign rsel_q = sel_e'(rsel_raw);

  assign s_arready = (rsel_q == SEL_UART) ? uart.arready : sram.arready;
  assign s_rvalid  = (rsel_q == SEL_UART) ? uart.rvalid  : sram.rvalid;
  assign s_rdata   = (rsel_q == SEL_UART) ? uart.rdata   : sram.rdata;
  assign s_rresp   = (rsel_q == SEL_UART) ? uart.rresp   : sram.rresp;

  always_comb begin
    live_d  = 1'b1;
    r_d     = r_q;
    rcap    = 1'b0;
    rdata_d = '0;
    rresp_d = RESP_DECERR;
    unique case (r_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (ar_sel == SEL_ERR) begin
            r_d  = R_RESP;
            rcap = 1'b1;
          end else begin
            r_d = R_ADDR;
          end
        end
      end
      R_ADDR: if (s_arready) r_d = R_WAIT;
      R_WAIT: begin
        if (s_rvalid) begin
          r_d     = R_RESP;
          rcap    = 1'b1;
          rdata_d = s_rdata;
          rresp_d = s_rresp;
        end
      end
      R_RESP:  if (up.rready) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  ysyx_24110015_Reg #(.WIDTH(32)) u_araddr (
    .clk (clk), .rst (rst), .din (up.araddr),
    .dout (araddr_q), .wen (ar_hs)
  );
  ysyx_24110015_Reg #(.WIDTH(2)) u_rsel (
    .clk (clk), .rst (rst), .din (ar_sel),
    .dout (rsel_raw), .wen (ar_hs)
  );
  ysyx_24110015_Reg #(.WIDTH(32)) u_rdata (
    .clk (clk), .rst (rst), .din (rdata_d),
    .dout (rdata_q), .wen (rcap)
  );
  ysyx_24110015_Reg #(.WIDTH(2)) u_rresp (
    .clk (clk), .rst (rst), .din (rresp_d),
    .dout (rresp_q), .wen (rcap)
  );

  assign up.arready   = live_q & (r_q == R_IDLE);
  assign up.rvalid    = (r_q == R_RESP);
  assign up.rdata     = rdata_q;
  assign up.rresp     = rresp_q;
  assign sram.arvalid = (r_q == R_ADDR) & (rsel_q == SEL_SRAM);
  assign uart.arvalid = (r_q == R_ADDR) & (rsel_q == SEL_UART);
  assign sram.rready  = (r_q == R_WAIT) & (rsel_q == SEL_SRAM);
  assign uart.rready  = (r_q == R_WAIT) & (rsel_q == SEL_UART);
  assign sram.araddr  = araddr_q;
  assign uart.araddr  = araddr_q;

  // decode the address as it will be held at the next edge
  assign aw_cur = aw_got_q ? awaddr_q : up.awaddr;

  ysyx_24110015_addr_decode u_wdec (
    .addr (aw_cur),
    .sel  (aw_sel)
  );

  assign aw_hs  = up.awvalid & up.awready;
  assign w_hs   = up.wvalid & up.wready;
  assign both   = (aw_got_q | aw_hs) & (w_got_q | w_hs);
  assign wsel_q = sel_e'(wsel_raw);

  assign s_awready = (wsel_q == SEL_UART) ? uart.awready : sram.awready;
  assign s_wready  = (wsel_q == SEL_UART) ? uart.wready  : sram.wready;
  assign s_bvalid  = (wsel_q == SEL_UART) ? uart.bvalid  : sram.bvalid;
  assign s_bresp   = (wsel_q == SEL_UART) ? uart.bresp   : sram.bresp;

  assign s_awvalid = (w_q == W_FWD) & ~aw_done_q;
  assign s_wvalid  = (w_q == W_FWD) & ~w_done_q;
  assign s_aw_hs   = s_awvalid & s_awready;
  assign s_w_hs    = s_wvalid & s_wready;

  always_comb begin
    w_d       = w_q;
    aw_got_d  = aw_got_q | aw_hs;
    w_got_d   = w_got_q | w_hs;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    sel_wen   = 1'b0;
    bcap      = 1'b0;
    bresp_d   = RESP_DECERR;
    unique case (w_q)
      W_IDLE: begin
        if (both) begin
          sel_wen = 1'b1;
          if (aw_sel == SEL_ERR) begin
            w_d  = W_RESP;
            bcap = 1'b1;
          end else begin
            w_d = W_FWD;
          end
        end
      end
      W_FWD: begin
        aw_done_d = aw_done_q | s_aw_hs;
        w_done_d  = w_done_q | s_w_hs;
        if (aw_done_d & w_done_d) begin
          w_d       = W_WAIT;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_WAIT: begin
        if (s_bvalid) begin
          w_d     = W_RESP;
          bcap    = 1'b1;
          bresp_d = s_bresp;
        end
      end
      W_RESP: begin
        if (up.bready) begin
          w_d      = W_IDLE;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end
      end
      default: w_d = W_IDLE;
    endcase
  end

  ysyx_24110015_Reg #(.WIDTH(32)) u_awaddr (
    .clk (clk), .rst (rst), .din (up.awaddr),
    .dout (awaddr_q), .wen (aw_hs)
  );
  ysyx_24110015_Reg #(.WIDTH(32)) u_wdata (
    .clk (clk), .rst (rst), .din (up.wdata),
    .dout (wdata_q), .wen (w_hs)
  );
  ysyx_24110015_Reg #(.WIDTH(4)) u_wstrb (
    .clk (clk), .rst (rst), .din (up.wstrb),
    .dout (wstrb_q), .wen (w_hs)
  );
  ysyx_24110015_Reg #(.WIDTH(2)) u_wsel (
    .clk (clk), .rst (rst), .din (aw_sel),
    .dout (wsel_raw), .wen (sel_wen)
  );
  ysyx_24110015_Reg #(.WIDTH(2)) u_bresp (
    .clk (clk), .rst (rst), .din (bresp_d),
    .dout (bresp_q), .wen (bcap)
  );

  assign up.awready   = live_q & (w_q == W_IDLE) & ~aw_got_q;
  assign up.wready    = live_q & (w_q == W_IDLE) & ~w_got_q;
  assign up.bvalid    = (w_q == W_RESP);
  assign up.bresp     = bresp_q;
  assign sram.awvalid = s_awvalid & (wsel_q == SEL_SRAM);
  assign uart.awvalid = s_awvalid & (wsel_q == SEL_UART);
  assign sram.wvalid  = s_wvalid & (wsel_q == SEL_SRAM);
  assign uart.wvalid  = s_wvalid & (wsel_q == SEL_UART);
  assign sram.bready  = (w_q == W_WAIT) & (wsel_q == SEL_SRAM);
  assign uart.bready  = (w_q == W_WAIT) & (wsel_q == SEL_UART);
  assign sram.awaddr  = awaddr_q;
  assign uart.awaddr  = awaddr_q;
  assign sram.wdata   = wdata_q;
  assign uart.wdata   = wdata_q;
  assign sram.wstrb   = wstrb_q;
  assign uart.wstrb   = wstrb_q;

endmodule

// File: tb/tb_ysyx_24110015_axi_xbar.sv
// Directed bench for the AXI-lite crossbar: vector table plus
// hand sequences for concurrency and mid-transaction reset.
module tb_ysyx_24110015_axi_xbar;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  axi_lite_if up_if ();
  axi_lite_if sram_if ();
  axi_lite_if uart_if ();

  ysyx_24110015_axi_xbar dut (
    .clk  (clk),
    .rst  (rst),
    .up   (up_if),
    .sram (sram_if),
    .uart (uart_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  // SRAM model: programmable read delay, AW then W split
  int          sram_delay = 0;
  logic [31:0] sram_rdata_v = '0;
  int          sram_rcnt;
  logic        sram_aw_seen;

  assign sram_if.arready = 1'b1;
  assign sram_if.awready = ~sram_aw_seen;
  assign sram_if.wready  = sram_aw_seen;
  assign sram_if.rresp   = 2'b00;
  assign sram_if.bresp   = 2'b00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_if.rvalid <= 1'b0;
      sram_if.rdata  <= '0;
      sram_if.bvalid <= 1'b0;
      sram_rcnt      <= 0;
      sram_aw_seen   <= 1'b0;
    end else begin
      if (sram_if.arvalid && sram_if.arready) begin
        if (sram_delay == 0) begin
          sram_if.rvalid <= 1'b1;
          sram_if.rdata  <= sram_rdata_v;
        end else begin
          sram_rcnt <= sram_delay;
        end
      end else if (sram_rcnt != 0) begin
        sram_rcnt <= sram_rcnt - 1;
        if (sram_rcnt == 1) begin
          sram_if.rvalid <= 1'b1;
          sram_if.rdata  <= sram_rdata_v;
        end
      end
      if (sram_if.rvalid && sram_if.rready) sram_if.rvalid <= 1'b0;
      if (sram_if.awvalid && sram_if.awready) sram_aw_seen <= 1'b1;
      if (sram_if.wvalid && sram_if.wready) begin
        sram_aw_seen   <= 1'b0;
        sram_if.bvalid <= 1'b1;
      end
      if (sram_if.bvalid && sram_if.bready) sram_if.bvalid <= 1'b0;
    end
  end

  // UART model: always ready, one-cycle bvalid pulse
  logic uart_aw_seen, uart_w_seen, uart_fire;

  assign uart_if.arready = 1'b1;
  assign uart_if.awready = 1'b1;
  assign uart_if.wready  = 1'b1;
  assign uart_if.rresp   = 2'b00;
  assign uart_if.bresp   = 2'b00;
  assign uart_fire = (uart_aw_seen | (uart_if.awvalid & uart_if.awready))
                   & (uart_w_seen | (uart_if.wvalid & uart_if.wready));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_if.rvalid <= 1'b0;
      uart_if.rdata  <= '0;
      uart_if.bvalid <= 1'b0;
      uart_aw_seen   <= 1'b0;
      uart_w_seen    <= 1'b0;
    end else begin
      if (uart_if.arvalid && uart_if.arready) begin
        uart_if.rvalid <= 1'b1;
        uart_if.rdata  <= 32'h0000_0055;
      end else if (uart_if.rvalid && uart_if.rready) begin
        uart_if.rvalid <= 1'b0;
      end
      uart_if.bvalid <= uart_fire;
      uart_aw_seen <= uart_fire ? 1'b0
                    : (uart_aw_seen | (uart_if.awvalid & uart_if.awready));
      uart_w_seen  <= uart_fire ? 1'b0
                    : (uart_w_seen | (uart_if.wvalid & uart_if.wready));
    end
  end

  int          sram_ar_n = 0, sram_aw_n = 0, sram_w_n = 0;
  int          uart_ar_n = 0, uart_aw_n = 0, uart_w_n = 0;
  logic [31:0] sram_last_wdata = '0, uart_last_wdata = '0;
  logic [3:0]  uart_last_wstrb = '0;

  always @(posedge clk) begin
    if (sram_if.arvalid && sram_if.arready) sram_ar_n <= sram_ar_n + 1;
    if (sram_if.awvalid && sram_if.awready) sram_aw_n <= sram_aw_n + 1;
    if (sram_if.wvalid && sram_if.wready) begin
      sram_w_n        <= sram_w_n + 1;
      sram_last_wdata <= sram_if.wdata;
    end
    if (uart_if.arvalid && uart_if.arready) uart_ar_n <= uart_ar_n + 1;
    if (uart_if.awvalid && uart_if.awready) uart_aw_n <= uart_aw_n + 1;
    if (uart_if.wvalid && uart_if.wready) begin
      uart_w_n        <= uart_w_n + 1;
      uart_last_wdata <= uart_if.wdata;
      uart_last_wstrb <= uart_if.wstrb;
    end
  end

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endfunction

  function automatic logic [14:0] outs();
    return {up_if.arready, up_if.rvalid, up_if.awready, up_if.wready,
            up_if.bvalid, sram_if.arvalid, sram_if.rready,
            sram_if.awvalid, sram_if.wvalid, sram_if.bready,
            uart_if.arvalid, uart_if.rready, uart_if.awvalid,
            uart_if.wvalid, uart_if.bready};
  endfunction

  task automatic do_read(input  logic [31:0] addr,
                         input  int          stall,
                         output logic [31:0] data,
                         output logic [1:0]  resp,
                         output int          lat,
                         output bit          hold_ok);
    int n;
    data = '0; resp = '0; lat = -1; hold_ok = 1'b1;
    @(negedge clk);
    up_if.araddr  = addr;
    up_if.arvalid = 1'b1;
    up_if.rready  = (stall == 0);
    n = 0;
    while (!up_if.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!up_if.arready) begin
      tmo("ar_accept");
      up_if.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    up_if.arvalid = 1'b0;
    lat = 1;
    while (!up_if.rvalid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!up_if.rvalid) begin
      tmo("rvalid");
      return;
    end
    data = up_if.rdata;
    resp = up_if.rresp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!up_if.rvalid || up_if.rdata !== data || up_if.rresp !== resp)
        hold_ok = 1'b0;
    end
    up_if.rready = 1'b1;
    @(negedge clk);
    up_if.rready = 1'b0;
  endtask

  task automatic do_write(input  logic [31:0] addr,
                          input  logic [31:0] data,
                          input  logic [3:0]  strb,
                          input  int          lead,
                          input  int          stall,
                          output logic [1:0]  resp,
                          output int          lat,
                          output bit          hold_ok);
    bit aw_ok, w_ok;
    int k;
    resp = '0; lat = -1; hold_ok = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; k = 0;
    up_if.bready = (stall == 0);
    while (!(aw_ok && w_ok) && k < 60) begin
      @(negedge clk);
      up_if.awaddr  = addr;
      up_if.wdata   = data;
      up_if.wstrb   = strb;
      up_if.awvalid = !aw_ok && (k >= lead);
      up_if.wvalid  = !w_ok;
      if (up_if.awvalid && up_if.awready) aw_ok = 1'b1;
      if (up_if.wvalid && up_if.wready) w_ok = 1'b1;
      k++;
    end
    if (!(aw_ok && w_ok)) begin
      tmo("aw_w_accept");
      up_if.awvalid = 1'b0;
      up_if.wvalid  = 1'b0;
      return;
    end
    @(negedge clk);
    up_if.awvalid = 1'b0;
    up_if.wvalid  = 1'b0;
    lat = 1;
    while (!up_if.bvalid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!up_if.bvalid) begin
      tmo("bvalid");
      return;
    end
    resp = up_if.bresp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!up_if.bvalid || up_if.bresp !== resp) hold_ok = 1'b0;
    end
    up_if.bready = 1'b1;
    @(negedge clk);
    up_if.bready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lead;
    int          stall;
    logic [31:0] srd;
    logic [31:0] erd;
    logic [1:0]  eresp;
    int          elat;
    int          esram;
    int          euart;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd, rd2;
    logic [1:0]  rs, bs;
    int          lat, lat2, n;
    int          s0, s1, u0, u1;
    bit          hold, hold2;
    vec_t        v;

    vecs[0]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 0,
                 32'hdead_beef, 32'hdead_beef, 2'b00, 3, 1, 0};
    vecs[1]  = '{1'b1, 32'ha000_03f8, 32'h41, 4'h1, 0, 3,
                 32'h0, 32'h0, 2'b00, 3, 0, 1};
    vecs[2]  = '{1'b1, 32'ha000_03f8, 32'h42, 4'h1, 2, 0,
                 32'h0, 32'h0, 2'b00, 3, 0, 1};
    vecs[3]  = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 0, 0,
                 32'h1111_1111, 32'h0, 2'b11, 1, 0, 0};
    vecs[4]  = '{1'b1, 32'h1000_0000, 32'h99, 4'hf, 0, 0,
                 32'h0, 32'h0, 2'b11, 1, 0, 0};
    vecs[5]  = '{1'b1, 32'h8000_0100, 32'h1234_5678, 4'hf, 0, 0,
                 32'h0, 32'h0, 2'b00, 4, 1, 0};
    vecs[6]  = '{1'b0, 32'ha000_03fc, 32'h0, 4'h0, 0, 0,
                 32'h0, 32'h55, 2'b00, 3, 0, 1};
    vecs[7]  = '{1'b0, 32'h87ff_fffc, 32'h0, 4'h0, 0, 0,
                 32'hcafe_f00d, 32'hcafe_f00d, 2'b00, 3, 1, 0};
    vecs[8]  = '{1'b0, 32'h8800_0000, 32'h0, 4'h0, 0, 0,
                 32'h2222_2222, 32'h0, 2'b11, 1, 0, 0};
    vecs[9]  = '{1'b0, 32'ha000_0400, 32'h0, 4'h0, 0, 0,
                 32'h3333_3333, 32'h0, 2'b11, 1, 0, 0};
    vecs[10] = '{1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, 4,
                 32'h0bad_f00d, 32'h0bad_f00d, 2'b00, 3, 1, 0};
    vecs[11] = '{1'b1, 32'ha000_03f0, 32'h77, 4'h1, 0, 0,
                 32'h0, 32'h0, 2'b11, 1, 0, 0};
    vecs[12] = '{1'b1, 32'h8000_0200, 32'h0000_aa55, 4'h3, 1, 0,
                 32'h0, 32'h0, 2'b00, 4, 1, 0};

    up_if.arvalid = 1'b0; up_if.araddr = '0; up_if.rready = 1'b0;
    up_if.awvalid = 1'b0; up_if.awaddr = '0; up_if.wvalid = 1'b0;
    up_if.wdata   = '0;   up_if.wstrb  = '0; up_if.bready = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outs", {17'b0, outs()}, 32'h0);
    chk("reset_rdata", up_if.rdata, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_c1_outs", {17'b0, outs()}, 32'h0);
    @(negedge clk);
    chk("rel_c2_ready",
        {29'b0, up_if.arready, up_if.awready, up_if.wready}, 32'h7);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      sram_rdata_v = v.srd;
      s0 = v.wr ? sram_aw_n : sram_ar_n;
      u0 = v.wr ? uart_aw_n : uart_ar_n;
      s1 = sram_w_n;
      u1 = uart_w_n;
      if (v.wr) begin
        do_write(v.addr, v.wdata, v.wstrb, v.lead, v.stall, rs, lat, hold);
      end else begin
        do_read(v.addr, v.stall, rd, rs, lat, hold);
        chk($sformatf("v%0d_rdata", i), rd, v.erd);
      end
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_resp", i), {30'b0, rs}, {30'b0, v.eresp});
      chk($sformatf("v%0d_lat", i), lat, v.elat);
      if (v.stall > 0) chk($sformatf("v%0d_hold", i), {31'b0, hold}, 32'h1);
      chk($sformatf("v%0d_sram_hs", i),
          (v.wr ? sram_aw_n : sram_ar_n) - s0, v.esram);
      chk($sformatf("v%0d_uart_hs", i),
          (v.wr ? uart_aw_n : uart_ar_n) - u0, v.euart);
      if (v.wr) begin
        chk($sformatf("v%0d_sram_w", i), sram_w_n - s1, v.esram);
        chk($sformatf("v%0d_uart_w", i), uart_w_n - u1, v.euart);
        if (v.euart != 0) begin
          chk($sformatf("v%0d_uart_wdata", i), uart_last_wdata, v.wdata);
          chk($sformatf("v%0d_uart_wstrb", i),
              {28'b0, uart_last_wstrb}, {28'b0, v.wstrb});
        end
        if (v.esram != 0)
          chk($sformatf("v%0d_sram_wdata", i), sram_last_wdata, v.wdata);
      end
    end

    sram_delay   = 5;
    sram_rdata_v = 32'h5eed_0001;
    s0 = sram_ar_n;
    u0 = uart_w_n;
    fork
      do_read(32'h8000_0020, 0, rd, rs, lat, hold);
      do_write(32'ha000_03f8, 32'h5a, 4'h1, 0, 0, bs, lat2, hold2);
    join
    repeat (2) @(negedge clk);
    chk("conc_rdata", rd, 32'h5eed_0001);
    chk("conc_rresp", {30'b0, rs}, 32'h0);
    chk("conc_rlat", lat, 8);
    chk("conc_bresp", {30'b0, bs}, 32'h0);
    chk("conc_wlat", lat2, 3);
    chk("conc_sram_ar", sram_ar_n - s0, 1);
    chk("conc_uart_w", uart_w_n - u0, 1);
    chk("conc_uart_wdata", uart_last_wdata, 32'h5a);

    sram_delay   = 10;
    sram_rdata_v = 32'h0bad_0bad;
    @(negedge clk);
    up_if.araddr  = 32'h8000_0030;
    up_if.arvalid = 1'b1;
    up_if.rready  = 1'b1;
    n = 0;
    while (!up_if.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    up_if.arvalid = 1'b0;
    n = 0;
    while (!sram_if.rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sram_if.rready) tmo("rwait_reach");
    rst = 1'b0;
    #1;
    chk("midrst_outs", {17'b0, outs()}, 32'h0);
    @(negedge clk);
    up_if.rready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_rel_c1", {17'b0, outs()}, 32'h0);
    @(negedge clk);
    chk("midrst_rel_c2",
        {29'b0, up_if.arready, up_if.awready, up_if.wready}, 32'h7);
    chk("midrst_no_rvalid", {31'b0, up_if.rvalid}, 32'h0);
    sram_delay   = 0;
    sram_rdata_v = 32'h600d_f00d;
    do_read(32'h8000_0034, 0, rd, rs, lat, hold);
    chk("post_rst_rdata", rd, 32'h600d_f00d);
    chk("post_rst_rresp", {30'b0, rs}, 32'h0);
    chk("post_rst_lat", lat, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_axi_xbar.md
# ysyx_24110015_axi_xbar

AXI-lite 1-to-2 crossbar between the core's memory-side AXI-lite master and its two slaves: SRAM and the UART sink. Decodes each read and write address and forwards the transaction to the matching slave. Registers the slave's response and returns it upstream. Unmapped addresses get an internal DECERR. Read and write paths are independent FSMs, each with at most one transaction outstanding.

## Interface
- UART_BASE, 32'ha000_03f8, UART window base
- UART_MASK, 32'hffff_fff8, UART match when (addr & UART_MASK) == UART_BASE
- SRAM_BASE, 32'h8000_0000, SRAM window base
- SRAM_MASK, 32'hf800_0000, SRAM match when (addr & SRAM_MASK) == SRAM_BASE
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- up  axi_lite_if.slave  —  from core; 32-bit addr/data, 4-bit wstrb, 2-bit resp
- sram  axi_lite_if.master  —  to SRAM slave
- uart  axi_lite_if.master  —  to UART slave

## Operation
- Decode priority: UART, then SRAM, else ERR (DECERR = 2'b11, rdata = 0).
- Read FSM:
  - R_IDLE: up.arready=1. On arvalid, latch araddr and decoded select. Go to R_ADDR, or to R_RESP with DECERR if unmapped.
  - R_ADDR: selected slave arvalid=1 with the latched addr. On slave arready, go to R_WAIT.
  - R_WAIT: selected slave rready=1. On slave rvalid, latch rdata/rresp and go to R_RESP.
  - R_RESP: up.rvalid=1 with the latched rdata/rresp. On up.rready, go to R_IDLE.
- Write FSM:
  - W_IDLE: up.awready = !aw_got and up.wready = !w_got. AW and W are latched independently, in either order or the same cycle. Once both are held, decode: go to W_FWD, or to W_RESP with DECERR.
  - W_FWD: selected slave awvalid and wvalid are driven independently. Each deasserts after its own handshake (aw_done, w_done). When both are done, go to W_WAIT. The UART accepts AW+W in the same cycle; SRAM may split them.
  - W_WAIT: selected slave bready=1. On slave bvalid, latch bresp and go to W_RESP. A one-cycle bvalid pulse from the slave must be captured.
  - W_RESP: up.bvalid=1 with the latched bresp. On up.bready, clear aw_got/w_got and go to W_IDLE.
- The unselected slave sees all valids/readies 0.
- The read and write paths may target the same slave concurrently; no cross-path ordering is enforced.
- wstrb is forwarded unchanged. The UART slave consumes only the low byte of wdata; the crossbar does no lane shifting.

## Timing
- While rst is low, and in the first cycle after release:
  - all valid and ready outputs are 0
  - FSMs are in R_IDLE/W_IDLE
  - latched regs and the got/done flags are 0
- Readies are asserted from the second cycle after rst goes high.
- Reset mid-transaction: abandon the transaction immediately with no response; downstream valids drop at once.
- Read latency, zero-wait slave: AR handshake in cycle 0; slave arvalid in cycle 1; slave rvalid in cycle 2; up.rvalid in cycle 3.
- Read DECERR: up.rvalid in cycle 1.
- Write latency, AW+W in same cycle 0: slave aw/w valid in cycle 1; bvalid captured in cycle 2; up.bvalid in cycle 3.
- Write DECERR: up.bvalid in the cycle after both AW and W are held.
- No combinational path from any upstream input to any downstream output, or back; all forwarded fields come from registers.
- Holding up.rready/up.bready low stalls the FSM in R_RESP/W_RESP indefinitely with data stable.
- A new AR is not accepted until R_RESP completes. AW/W are not accepted until W_RESP completes.

## Structure
- Package ysyx_24110015_axi_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_DECERR=2'b11
  - select enum {SEL_SRAM, SEL_UART, SEL_ERR}
  - read and write state enums
- Sub-module ysyx_24110015_addr_decode: combinational addr → select. Instantiated twice, once for the read path and once for the write path.
- Latches use the existing ysyx_24110015_Reg with wen.

## Test plan
- Read 0x8000_0010: SRAM returns 0xdeadbeef, OKAY, with zero wait → up.rvalid in cycle 3, rdata 0xdeadbeef, rresp 00; uart.arvalid never asserted.
- Write 0xa000_03f8, wdata 0x41, wstrb 4'b0001, AW+W same cycle; UART pulses bvalid for 1 cycle → uart sees one aw/w handshake, up.bvalid held with bresp 00 until bready, sram untouched.
- Write with W two cycles before AW → W latched first, forwarded once AW arrives; exactly one slave handshake per channel.
- Read 0x1000_0000 → up.rvalid in cycle 1, rresp 11, rdata 0; no slave valid asserted. Write to the same address → bresp 11.
- Concurrent: SRAM read with a 5-cycle slave delay and a UART write issued together → both complete independently, correct data and responses.
- rst low while in R_WAIT → all outputs 0 immediately; after release, a fresh read to SRAM completes normally with no stale response.
